alu_cmd_issuer: RTL

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer_if.sv | 57 +++++
 rtl/alu_cmd_issuer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if
//   Bundles the three buses around the ALU command issuer:
//     req_*  : host request channel (valid/ready, operands, command, tag)
//     rsp_*  : host response channel (valid/ready, result, flags, tag)
//     drive  : opa_1/opb_1/cmd/mode/cin/ce/inp_valid towards the ALU
//     result : res/cout/oflow/g/e/l/err returned by the ALU
//   slave  : the issuer's view.
//   master : the surrounding host + ALU view.
interface alu_cmd_issuer_if #(
    parameter int WIDTH_O   = 8,
    parameter int WIDTH_C   = 4,
    parameter int WIDTH_RES = 2*WIDTH_O,
    parameter int TAG_W     = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic [WIDTH_O-1:0]   req_opa;
    logic [WIDTH_O-1:0]   req_opb;
    logic [WIDTH_C-1:0]   req_cmd;
    logic                 req_mode;
    logic                 req_cin;
    logic [1:0]           req_inp_valid;
    logic [TAG_W-1:0]     req_tag;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WIDTH_RES-1:0] rsp_res;
    logic                 rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err;
    logic [TAG_W-1:0]     rsp_tag;

    logic [WIDTH_O-1:0]   opa_1;
    logic [WIDTH_O-1:0]   opb_1;
    logic [WIDTH_C-1:0]   cmd;
    logic                 mode, cin, ce;
    logic [1:0]           inp_valid;

    logic [WIDTH_RES-1:0] res;
    logic                 cout, oflow, g, e, l, err;

    modport slave (
        input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inp_valid, req_tag,
        output req_ready,
        output rsp_valid, rsp_res, rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err, rsp_tag,
        input  rsp_ready,
        output opa_1, opb_1, cmd, mode, cin, ce, inp_valid,
        input  res, cout, oflow, g, e, l, err
    );

    modport master (
        output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inp_valid, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_res, rsp_cout, rsp_oflow, rsp_g, rsp_e, rsp_l, rsp_err, rsp_tag,
        output rsp_ready,
        input  opa_1, opb_1, cmd, mode, cin, ce, inp_valid,
        output res, cout, oflow, g, e, l, err
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Accepts ALU requests into a 2-entry FIFO, issues them one at a time to a
//   multi-cycle ALU through registered drive outputs, waits a command-dependent
//   latency, captures the ALU result and presents it on the response channel.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : alu_cmd_issuer_if.slave (request, response, ALU drive, ALU result)
//
//   state   | meaning
//   IDLE    | no operation in flight; pops FIFO head when available
//   DRIVE   | operands held on the ALU inputs, latency counter running
//   CAPTURE | one settling cycle; ALU result registered at its end
//   RESP    | response held until the host takes it
module alu_cmd_issuer #(
    parameter int WIDTH_O   = 8,
    parameter int WIDTH_C   = 4,
    parameter int WIDTH_RES = 2*WIDTH_O,
    parameter int TAG_W     = 4
) (
    input logic clk,
    input logic rst_n,
    alu_cmd_issuer_if.slave bus
);
    localparam int ENTRY_W = 2*WIDTH_O + WIDTH_C + 4 + TAG_W;
    localparam logic [WIDTH_C-1:0] CMD_INC_MUL = WIDTH_C'(4'b1001);
    localparam logic [WIDTH_C-1:0] CMD_SHL_MUL = WIDTH_C'(4'b1010);

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;

    state_t state_q, state_d;
    logic [1:0] lat_q, lat_d, lat_load;

    logic [ENTRY_W-1:0] mem_q [2];
    logic [ENTRY_W-1:0] mem_d [2];
    logic [ENTRY_W-1:0] head;
    logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               ready_en_q;
    logic               push, pop, fifo_empty;

    logic [WIDTH_O-1:0] h_opa, h_opb;
    logic [WIDTH_C-1:0] h_cmd;
    logic               h_mode, h_cin;
    logic [1:0]         h_iv;
    logic [TAG_W-1:0]   h_tag;

    logic [WIDTH_O-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH_C-1:0]   cmd_q, cmd_d;
    logic                 mode_q, mode_d, cin_q, cin_d, ce_q, ce_d;
    logic [1:0]           inp_valid_q, inp_valid_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WIDTH_RES-1:0] rsp_res_q, rsp_res_d;
    logic [5:0]           rsp_flg_q, rsp_flg_d;
    logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;

    // ready_en_q keeps the request port closed while reset is held and opens
    // it on the first edge afterwards.
    assign bus.req_ready = ready_en_q && (count_q != 2'd2);
    assign push          = bus.req_valid && bus.req_ready;
    assign fifo_empty    = (count_q == 2'd0);
    assign pop           = (state_q == IDLE) && !fifo_empty;
    assign head          = mem_q[rd_ptr_q];
    assign {h_opa, h_opb, h_cmd, h_mode, h_cin, h_iv, h_tag} = head;
    assign lat_load = (h_mode && (h_cmd == CMD_INC_MUL || h_cmd == CMD_SHL_MUL)) ? 2'd3 : 2'd2;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.req_opa, bus.req_opb, bus.req_cmd, bus.req_mode,
                               bus.req_cin, bus.req_inp_valid, bus.req_tag};
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_q       <= 2'd0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            ready_en_q  <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            ce_q        <= 1'b0;
            inp_valid_q <= 2'b00;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flg_q   <= '0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_en_q  <= 1'b1;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cmd_q       <= cmd_d;
            mode_q      <= mode_d;
            cin_q       <= cin_d;
            ce_q        <= ce_d;
            inp_valid_q <= inp_valid_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flg_q   <= rsp_flg_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    // DRIVE lasts lat_q cycles: the counter is loaded with the latency and the
    // terminal count of 1 marks the last DRIVE cycle.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = DRIVE;
                    lat_d   = lat_load;
                end
            end
            DRIVE: begin
                if (lat_q == 2'd1) state_d = CAPTURE;
                else               lat_d   = lat_q - 2'd1;
            end
            CAPTURE: state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        opa_d       = opa_q;
        opb_d       = opb_q;
        cmd_d       = cmd_q;
        mode_d      = mode_q;
        cin_d       = cin_q;
        ce_d        = ce_q;
        inp_valid_d = inp_valid_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_flg_d   = rsp_flg_q;
        rsp_tag_d   = rsp_tag_q;
        if (pop) begin
            opa_d       = h_opa;
            opb_d       = h_opb;
            cmd_d       = h_cmd;
            mode_d      = h_mode;
            cin_d       = h_cin;
            inp_valid_d = h_iv;
            tag_d       = h_tag;
            ce_d        = 1'b1;
        end
        if (state_q == CAPTURE) begin
            ce_d        = 1'b0;
            inp_valid_d = 2'b00;
            rsp_valid_d = 1'b1;
            rsp_res_d   = bus.res;
            rsp_flg_d   = {bus.err, bus.l, bus.e, bus.g, bus.oflow, bus.cout};
            rsp_tag_d   = tag_q;
        end
        if (state_q == RESP && bus.rsp_ready) rsp_valid_d = 1'b0;
    end

    assign bus.opa_1     = opa_q;
    assign bus.opb_1     = opb_q;
    assign bus.cmd       = cmd_q;
    assign bus.mode      = mode_q;
    assign bus.cin       = cin_q;
    assign bus.ce        = ce_q;
    assign bus.inp_valid = inp_valid_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_res   = rsp_res_q;
    assign {bus.rsp_err, bus.rsp_l, bus.rsp_e, bus.rsp_g, bus.rsp_oflow, bus.rsp_cout} = rsp_flg_q;
    assign bus.rsp_tag   = rsp_tag_q;
endmodule
